phos_fec_v2_adc_remap: RTL
==========================

Name: phos_fec_v2_adc_remap

Overview:
Runtime-programmable ADC channel remapper. It replaces the fixed board-wiring swap between the ADC deserialisers and the sample buffers. The map is a shadow/active table pair: software writes the shadow table, and a commit applies it atomically during a gap in the sample stream. Output is registered and carries a valid strobe; per-channel disable and table readback are included.

Parameters:
ADC_BITS, 12, bits per sample
ADC_CHIPS, 2, number of ADC chips
ADC_CHIP_NCH, 32, channels per chip; ADC_NCH = ADC_CHIPS*ADC_CHIP_NCH (localparam)
IDX_W, 6, source/address index width; must satisfy 2**IDX_W >= ADC_NCH
RESET_MAP, 1, reset/default map: 0 = identity, 1 = FEC board map (legal only when ADC_NCH=64)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
adc_pdata_i  in  ADC_NCH*ADC_BITS  input samples, channel n at [(n+1)*ADC_BITS-1 : n*ADC_BITS]
adc_valid_i  in  1  input sample word valid
adc_pdata_o  out  ADC_NCH*ADC_BITS  remapped samples, same packing
adc_valid_o  out  1  output valid
map_wr_i  in  1  shadow-table write strobe
map_addr_i  in  IDX_W  output channel for write/readback
map_src_i  in  IDX_W  source channel for write
map_en_i  in  1  channel enable for write
map_commit_i  in  1  request shadow->active transfer
map_rd_src_o  out  IDX_W  shadow source at map_addr_i, 1-cycle latency
map_rd_en_o  out  1  shadow enable at map_addr_i, 1-cycle latency
map_busy_o  out  1  commit pending
map_err_o  out  1  sticky: write with addr or src >= ADC_NCH

Behaviour:
- Table entry per output channel k: {en, src}. Output k = en ? in[src] : 0. src >= ADC_NCH yields 0.
- Default map, identical for both tables at reset:
  - RESET_MAP=0: src[k]=k, en=1.
  - RESET_MAP=1, for j=0..7, en=1:
    - out[2j]=in[4j], out[2j+1]=in[4j+1]
    - out[16+2j]=in[61-4j], out[17+2j]=in[60-4j]
    - out[32+2j]=in[4j+2], out[33+2j]=in[4j+3]
    - out[48+2j]=in[63-4j], out[49+2j]=in[62-4j]
- Datapath latency is exactly 1 cycle:
  - Every edge: adc_pdata_o <= mux(active table, adc_pdata_i); adc_valid_o <= adc_valid_i.
  - Data is registered even when valid=0.
- Write: map_wr_i=1 updates shadow[map_addr_i] at the edge.
  - addr >= ADC_NCH: write ignored, map_err_o set.
  - src >= ADC_NCH: written, map_err_o set.
  - map_err_o is cleared only by reset.
- Readback: map_rd_* <= shadow[map_addr_i] each edge. A same-cycle write is visible on the following cycle's readback.
- Commit FSM, two states:
  - IDLE: map_commit_i -> PEND.
  - PEND (map_busy_o=1): on any cycle with adc_valid_i=0, copy whole shadow to active at that edge -> IDLE.
  - Words with adc_valid_i=1 always use one consistent table; a word is never mixed-map.
- The copy takes the shadow state after any same-edge write, so writes issued while PEND are included.
- Commit while PEND: no effect.
- A commit and adc_valid_i=0 in the same cycle: transition to PEND only; the copy occurs at the earliest next idle cycle.
- Commit never completes while adc_valid_i stays 1 (documented; no timeout).
- Reset (any time, including mid-PEND):
  - Both tables return to default; FSM -> IDLE.
  - adc_pdata_o=0, adc_valid_o=0, map_busy_o=0, map_err_o=0, map_rd_src_o=0, map_rd_en_o=0.
- Table storage is flops, not RAM; the full-table copy happens in one cycle.

Test Plan:
- Reset, RESET_MAP=1, in[n]=n (12-bit), valid=1 -> next cycle out[0]=0, out[2]=4, out[16]=61, out[17]=60, out[32]=2, out[48]=63, out[63]=34; valid_o follows valid_i with 1-cycle delay.
- Write shadow[5]={en=1, src=40}, no commit -> out[5] unchanged; readback addr 5 gives src=40, en=1 one cycle later.
- Commit while valid=1 for 10 cycles, then one idle cycle:
  - map_busy_o=1 throughout the valid run;
  - all 10 words use the old map;
  - table swaps at the idle edge; first later word has out[5]=in[40]; busy drops.
- Write {en=0} to addr 3, commit, idle -> out[3]=0 while other channels are unaffected.
- Write addr=70 (IDX_W=7 build) -> table unchanged, map_err_o=1 and sticky. Write src=66 (ADC_NCH=64, IDX_W=7) -> that output reads 0 after commit.
- Assert rst_i while PEND with a modified shadow -> busy=0, outputs 0, readback shows default map, next data uses default map.

Source files
------------

// File: rtl/phos_fec_v2_adc_remap_if.sv
// phos_fec_v2_adc_remap_if
//   Bundles the sample stream and the map-programming port of the ADC
//   channel remapper.
//   slave  : used by the remapper (samples/programming in, remapped samples,
//            readback and status out)
//   master : used by the producer/software side
interface phos_fec_v2_adc_remap_if #(
  parameter int unsigned ADC_BITS = 12,
  parameter int unsigned ADC_NCH  = 64,
  parameter int unsigned IDX_W    = 6
);
  logic [ADC_NCH*ADC_BITS-1:0] adc_pdata_i;
  logic                        adc_valid_i;
  logic [ADC_NCH*ADC_BITS-1:0] adc_pdata_o;
  logic                        adc_valid_o;
  logic                        map_wr_i;
  logic [IDX_W-1:0]            map_addr_i;
  logic [IDX_W-1:0]            map_src_i;
  logic                        map_en_i;
  logic                        map_commit_i;
  logic [IDX_W-1:0]            map_rd_src_o;
  logic                        map_rd_en_o;
  logic                        map_busy_o;
  logic                        map_err_o;

  modport slave (
    input  adc_pdata_i, adc_valid_i, map_wr_i, map_addr_i, map_src_i,
           map_en_i, map_commit_i,
    output adc_pdata_o, adc_valid_o, map_rd_src_o, map_rd_en_o,
           map_busy_o, map_err_o
  );

  modport master (
    output adc_pdata_i, adc_valid_i, map_wr_i, map_addr_i, map_src_i,
           map_en_i, map_commit_i,
    input  adc_pdata_o, adc_valid_o, map_rd_src_o, map_rd_en_o,
           map_busy_o, map_err_o
  );
endinterface

// File: rtl/phos_fec_v2_adc_remap.sv
// phos_fec_v2_adc_remap
//   Runtime-programmable ADC channel remapper. Software programs a shadow
//   table; a commit copies it into the active table on the first cycle with
//   no valid input word, so no valid word is ever built from two maps.
//   Output word k = active.en[k] ? in[active.src[k]] : 0, registered once.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset (tables back to default map)
//   bus    slave modport: samples in/out with valid, shadow-table write,
//          readback (1-cycle latency), commit busy, sticky address/source error
module phos_fec_v2_adc_remap #(
  parameter int unsigned ADC_BITS     = 12,
  parameter int unsigned ADC_CHIPS    = 2,
  parameter int unsigned ADC_CHIP_NCH = 32,
  parameter int unsigned IDX_W        = 6,
  parameter int unsigned RESET_MAP    = 1
) (
  input logic                          clk_i,
  input logic                          rst_i,
  phos_fec_v2_adc_remap_if.slave       bus
);
  localparam int unsigned ADC_NCH = ADC_CHIPS * ADC_CHIP_NCH;
  localparam logic [IDX_W:0] NCH_L = (IDX_W+1)'(ADC_NCH);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  // Default source for output k. The FEC map interleaves pairs from four
  // 16-channel groups: direct even pairs, reversed pairs from the top,
  // direct odd pairs, reversed pairs from the very top.
  function automatic logic [IDX_W-1:0] dflt_src(int unsigned k);
    int unsigned j, odd, v;
    j   = (k % 16) / 2;
    odd = k % 2;
    if (RESET_MAP == 0) begin
      v = k;
    end else begin
      case (k / 16)
        0:       v = 4*j + odd;
        1:       v = 61 - 4*j - odd;
        2:       v = 4*j + 2 + odd;
        default: v = 63 - 4*j - odd;
      endcase
    end
    return IDX_W'(v);
  endfunction

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            sh_src_q  [ADC_NCH];
  logic [IDX_W-1:0]            sh_src_d  [ADC_NCH];
  logic [IDX_W-1:0]            act_src_q [ADC_NCH];
  logic [IDX_W-1:0]            act_src_d [ADC_NCH];
  logic [ADC_NCH-1:0]          sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [ADC_NCH*ADC_BITS-1:0] pdata_q, pdata_d;
  logic                        valid_q, valid_d;
  logic [IDX_W-1:0]            rd_src_q, rd_src_d;
  logic                        rd_en_q, rd_en_d;
  logic                        err_q, err_d;

  always_comb begin
    state_d   = state_q;
    sh_src_d  = sh_src_q;
    sh_en_d   = sh_en_q;
    act_src_d = act_src_q;
    act_en_d  = act_en_q;
    err_d     = err_q;
    rd_src_d  = '0;
    rd_en_d   = 1'b0;
    valid_d   = bus.adc_valid_i;
    pdata_d   = '0;

    // Address decode by comparison keeps the tables indexable for any IDX_W;
    // an out-of-range address simply matches no entry.
    for (int unsigned k = 0; k < ADC_NCH; k++) begin
      if (bus.map_addr_i == IDX_W'(k)) begin
        rd_src_d = sh_src_q[k];
        rd_en_d  = sh_en_q[k];
        if (bus.map_wr_i) begin
          sh_src_d[k] = bus.map_src_i;
          sh_en_d[k]  = bus.map_en_i;
        end
      end
    end

    if (bus.map_wr_i &&
        (({1'b0, bus.map_addr_i} >= NCH_L) || ({1'b0, bus.map_src_i} >= NCH_L)))
      err_d = 1'b1;

    for (int unsigned k = 0; k < ADC_NCH; k++) begin
      if (act_en_q[k] && ({1'b0, act_src_q[k]} < NCH_L))
        pdata_d[k*ADC_BITS +: ADC_BITS] =
          bus.adc_pdata_i[act_src_q[k]*ADC_BITS +: ADC_BITS];
    end

    // The copy takes sh_*_d so a write on the swap edge is included.
    case (state_q)
      ST_IDLE: if (bus.map_commit_i) state_d = ST_PEND;
      ST_PEND: begin
        if (!bus.adc_valid_i) begin
          act_src_d = sh_src_d;
          act_en_d  = sh_en_d;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < ADC_NCH; k++) begin
        sh_src_q[k]  <= dflt_src(k);
        act_src_q[k] <= dflt_src(k);
      end
      sh_en_q  <= '1;
      act_en_q <= '1;
      state_q  <= ST_IDLE;
      pdata_q  <= '0;
      valid_q  <= 1'b0;
      rd_src_q <= '0;
      rd_en_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sh_src_q  <= sh_src_d;
      act_src_q <= act_src_d;
      sh_en_q   <= sh_en_d;
      act_en_q  <= act_en_d;
      state_q   <= state_d;
      pdata_q   <= pdata_d;
      valid_q   <= valid_d;
      rd_src_q  <= rd_src_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
    end
  end

  assign bus.adc_pdata_o  = pdata_q;
  assign bus.adc_valid_o  = valid_q;
  assign bus.map_rd_src_o = rd_src_q;
  assign bus.map_rd_en_o  = rd_en_q;
  assign bus.map_busy_o   = (state_q == ST_PEND);
  assign bus.map_err_o    = err_q;
endmodule
